// File: rtl/sprite_bram_writer_pkg.sv
// Shared definitions for the sprite BRAM writer.
//   - state_t       : writer FSM states (IDLE, LOAD, FLUSH, DONE)
//   - SPR_W_DEF/H   : default sprite geometry in pixels
//   - PIX_PER_WORD  : 4-bit pixels packed per 32-bit BRAM word
//   - cnt_width()   : counter width for a given pixel count (never 0)
package sprite_bram_writer_pkg;

   localparam int SPR_W_DEF    = 266;
   localparam int SPR_H_DEF    = 64;
   localparam int PIX_PER_WORD = 8;
   localparam int NIB_W        = 4;
   localparam int WORD_W       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_bram_writer_nibble_packer.sv
// nibble_packer: collects up to eight 4-bit pixels into one 32-bit word.
// Pixel k of a word lands in bits [31-4k:28-4k] (first pixel in the MSBs);
// nibbles not yet filled are zero, so a partial word can be written as-is.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : synchronous clear of word and fill count
//   i_push       : accept i_nib into slot o_fill
//   i_nib        : incoming pixel
//   o_fill       : slot the next pixel goes to (0..7)
//   o_word_next  : current word with i_nib already placed in slot o_fill
module nibble_packer
   import sprite_bram_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [NIB_W-1:0]  i_nib,
   output logic [2:0]        o_fill,
   output logic [WORD_W-1:0] o_word_next
);

   logic [WORD_W-1:0] r_word;
   logic [2:0]        r_fill;
   logic [WORD_W-1:0] w_word_next;

   always_comb begin
      w_word_next = r_word;
      for (int k = 0; k < PIX_PER_WORD; k++) begin
         if (r_fill == 3'(k)) begin
            w_word_next[WORD_W-1-NIB_W*k -: NIB_W] = i_nib;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_fill <= '0;
      end else if (i_clear) begin
         r_word <= '0;
         r_fill <= '0;
      end else if (i_push) begin
         if (r_fill == 3'd7) begin
            // The completed word leaves through o_word_next this cycle;
            // start the next one from all-zero nibbles.
            r_word <= '0;
            r_fill <= '0;
         end else begin
            r_word <= w_word_next;
            r_fill <= r_fill + 3'd1;
         end
      end
   end

   assign o_fill      = r_fill;
   assign o_word_next = w_word_next;

endmodule

// File: rtl/sprite_bram_writer.sv
// sprite_bram_writer: streams one sprite of SPR_W x SPR_H 4-bit palette
// indices (raster order) into a 32-bit BRAM, eight pixels per word, word
// address = pixel_index / 8.
// Handshake: a pixel is transferred on a rising edge where pix_valid and
// pix_ready are both high; pix_valid may drop at any time and simply holds
// all progress.
// Ports:
//   clk_125MHz, reset_n : clock, asynchronous active-low reset
//   start               : one-cycle load request, honoured only in IDLE
//   pix_data/valid/ready: pixel stream
//   addra, dina, wea    : BRAM port A (registered; wea=4'hF for one cycle per word)
//   busy                : high in LOAD and FLUSH
//   done                : one-cycle pulse after the final word is written
//   o_state             : current FSM state, for observation
module sprite_bram_writer
   import sprite_bram_writer_pkg::*;
#(
   parameter int SPR_W  = SPR_W_DEF,
   parameter int SPR_H  = SPR_H_DEF,
   parameter int ADDR_W = 12
)(
   input  logic              clk_125MHz,
   input  logic              reset_n,
   input  logic              start,
   input  logic [3:0]        pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] addra,
   output logic [31:0]       dina,
   output logic [3:0]        wea,
   output logic              busy,
   output logic              done,
   output state_t            o_state
);

   localparam int     NPIX      = SPR_W * SPR_H;
   localparam int     CNT_W     = cnt_width(NPIX);
   localparam longint NWORDS    = (longint'(NPIX) + PIX_PER_WORD - 1) / PIX_PER_WORD;
   localparam longint ADDR_SPAN = longint'(1) << ADDR_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

   generate
      if (NWORDS > ADDR_SPAN) begin : g_addr_check
         $error("sprite_bram_writer: sprite needs more words than ADDR_W can address");
      end
   endgenerate

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_pix_cnt;
   logic [ADDR_W-1:0] r_word_addr;
   logic              r_all_in;
   logic [ADDR_W-1:0] r_addra;
   logic [31:0]       r_dina;
   logic [3:0]        r_wea;

   logic              w_pix_ready;
   logic              w_accept;
   logic              w_clear;
   logic              w_last;
   logic              w_word_full;
   logic              w_write;
   logic [2:0]        w_fill;
   logic [31:0]       w_word_next;

   nibble_packer u_packer (
      .clk         (clk_125MHz),
      .rst_n       (reset_n),
      .i_clear     (w_clear),
      .i_push      (w_accept),
      .i_nib       (pix_data),
      .o_fill      (w_fill),
      .o_word_next (w_word_next)
   );

   assign w_accept    = pix_valid && w_pix_ready;
   assign w_clear     = (r_state == ST_IDLE) && start;
   assign w_last      = (r_pix_cnt == LAST_IDX);
   assign w_word_full = (w_fill == 3'd7);
   // The final pixel always closes a word, full or not.
   assign w_write     = w_accept && (w_word_full || w_last);

   always_ff @(posedge clk_125MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // r_all_in marks that the last pixel has been taken: pix_ready drops so
   // nothing can be accepted past the final address.
   always_comb begin
      w_state_next = r_state;
      w_pix_ready  = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy        = 1'b1;
            w_pix_ready = !r_all_in;
            if (r_all_in) begin
               // Write cycle of a final full word is in progress.
               w_state_next = ST_DONE;
            end else if (w_accept && w_last) begin
               w_state_next = w_word_full ? ST_LOAD : ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            busy         = 1'b1;
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // The BRAM port is registered at acceptance of the word-closing pixel, so
   // the write (full word, or the zero-padded partial word during FLUSH)
   // appears exactly one cycle later.
   always_ff @(posedge clk_125MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_cnt   <= '0;
         r_word_addr <= '0;
         r_all_in    <= 1'b0;
         r_addra     <= '0;
         r_dina      <= '0;
         r_wea       <= '0;
      end else begin
         r_wea <= 4'b0000;
         if (w_clear) begin
            r_pix_cnt   <= '0;
            r_word_addr <= '0;
            r_all_in    <= 1'b0;
         end else if (w_accept) begin
            if (w_last) begin
               r_all_in <= 1'b1;
            end else begin
               r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_write) begin
               r_wea   <= 4'b1111;
               r_addra <= r_word_addr;
               r_dina  <= w_word_next;
               if (!w_last) begin
                  r_word_addr <= r_word_addr + 1'b1;
               end
            end
         end
      end
   end

   assign pix_ready = w_pix_ready;
   assign addra     = r_addra;
   assign dina      = r_dina;
   assign wea       = r_wea;
   assign o_state   = r_state;

endmodule
